// File: rtl/cnt_pkg.sv
// Shared types for the loadable down-counter/timer.
// State encoding is kept here so checkers and the top agree on it.
package cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous reset and clear.
// Used to count auto-reload wraps of the down-timer.
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign q = r_cnt;

endmodule

// File: rtl/cnt_dn_timer.sv
// Loadable down-counter/timer with valid/ready load, tc pulse and auto-reload.
// Optional wrap counter (wraps port, WRAPW parameter) under CNT_DN_WRAPCNT_EN.
module cnt_dn_timer
    import cnt_pkg::*;
#(
    parameter int n = 4
`ifdef CNT_DN_WRAPCNT_EN
    , parameter int WRAPW = 8
`endif
) (
    input  logic         Clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         auto_rl,
    input  logic         ld_valid,
    output logic         ld_ready,
    input  logic [n-1:0] D,
    output logic [n-1:0] q,
    output logic         busy,
    output logic         done,
    output logic         tc
`ifdef CNT_DN_WRAPCNT_EN
    , output logic [WRAPW-1:0] wraps
`endif
);

    // Load handshake: a load is taken on an edge where ld_valid && ld_ready,
    // ld_ready is high whenever the FSM is not in RUN, and clr drops the load.
    cnt_state_t   r_state;
    logic [n-1:0] r_q;
    logic [n-1:0] r_rl;
    logic         r_tc;

    cnt_state_t   w_state_nxt;
    logic [n-1:0] w_q_nxt;
    logic [n-1:0] w_rl_nxt;
    logic         w_tc_nxt;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_rl    <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_rl    <= w_rl_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_rl_nxt    = r_rl;
        w_tc_nxt    = 1'b0;
        if (clr) begin
            w_state_nxt = IDLE;
            w_q_nxt     = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (en) begin
                        if (r_q > n'(1)) begin
                            w_q_nxt = r_q - n'(1);
                        end else begin
                            // Terminal count: reload keeps the period at r_rl cycles.
                            w_tc_nxt = 1'b1;
                            if (auto_rl) begin
                                w_q_nxt = r_rl;
                            end else begin
                                w_q_nxt     = '0;
                                w_state_nxt = DONE;
                            end
                        end
                    end
                end
                default: begin
                    if (ld_valid) begin
                        w_q_nxt  = D;
                        w_rl_nxt = D;
                        if (D != '0) begin
                            w_state_nxt = RUN;
                        end else begin
                            w_state_nxt = DONE;
                            w_tc_nxt    = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign q        = r_q;
    assign tc       = r_tc;
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign ld_ready = (r_state != RUN);

`ifdef CNT_DN_WRAPCNT_EN
    logic w_load_fire;
    logic w_wrap_inc;

    assign w_load_fire = ld_valid && (r_state != RUN) && !clr;
    assign w_wrap_inc  = (r_state == RUN) && en && !clr && (r_q <= n'(1)) && auto_rl;

    sat_cnt #(.W(WRAPW)) u_wrap_cnt (
        .clk   (Clk),
        .reset (reset),
        .clr   (w_load_fire),
        .inc   (w_wrap_inc),
        .q     (wraps)
    );
`endif

endmodule

// File: tb/tb_cnt_dn_timer.sv
// Self-checking bench for cnt_dn_timer (n=4) against a behavioural model.
// Wrap-count checks are compiled in only with CNT_DN_WRAPCNT_EN.
module tb_cnt_dn_timer;

    localparam int N = 4;

    logic         Clk;
    logic         reset;
    logic         en;
    logic         clr;
    logic         auto_rl;
    logic         ld_valid;
    logic         ld_ready;
    logic [N-1:0] D;
    logic [N-1:0] q;
    logic         busy;
    logic         done;
    logic         tc;
`ifdef CNT_DN_WRAPCNT_EN
    logic [7:0]   wraps;
`endif

    cnt_dn_timer #(.n(N)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .en       (en),
        .clr      (clr),
        .auto_rl  (auto_rl),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .D        (D),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .tc       (tc)
`ifdef CNT_DN_WRAPCNT_EN
        , .wraps  (wraps)
`endif
    );

    // clock / reset block
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model: mode 0 = idle, 1 = counting, 2 = finished
    int m_mode;
    int m_q;
    int m_rl;
    int m_tc;
    int m_wraps;

    logic [7:0] obs;
    logic [7:0] exp_v;

    // Advance the model by the rules for the inputs presented at this edge,
    // then clock the DUT and land 1 time unit after the edge.
    task automatic step();
        if (reset) begin
            m_mode = 0; m_q = 0; m_rl = 0; m_tc = 0; m_wraps = 0;
        end else if (clr) begin
            m_mode = 0; m_q = 0; m_tc = 0;
        end else if (m_mode != 1) begin
            m_tc = 0;
            if (ld_valid) begin
                m_q = int'(D); m_rl = int'(D); m_wraps = 0;
                if (D == 0) begin m_mode = 2; m_tc = 1; end
                else m_mode = 1;
            end
        end else begin
            m_tc = 0;
            if (en) begin
                if (m_q >= 2) m_q = m_q - 1;
                else begin
                    m_tc = 1;
                    if (auto_rl) begin
                        m_q = m_rl;
                        if (m_wraps < 255) m_wraps = m_wraps + 1;
                    end else begin
                        m_q = 0; m_mode = 2;
                    end
                end
            end
        end
        @(posedge Clk);
        #1;
        obs   = {busy, done, ld_ready, tc, q};
        exp_v = {(m_mode == 1), (m_mode == 2), (m_mode != 1), (m_tc != 0), 4'(m_q)};
    endtask

    task automatic idle_inputs();
        reset = 0; en = 0; clr = 0; auto_rl = 0; ld_valid = 0; D = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; ld_valid = 1; D = 4'd7;
        for (int i = 0; i < 2; i++) step();
        n_tests++;
        if (obs !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", obs, 8'b0010_0000);
        end
        reset = 0; ld_valid = 0;
`ifdef CNT_DN_WRAPCNT_EN
        n_tests++;
        if (wraps !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_wraps: got %0d expected 0", wraps);
        end
`endif
    endtask

    task automatic test_oneshot();
        logic [3:0] exp_q [4] = '{4'd3, 4'd2, 4'd1, 4'd0};
        logic       exp_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        idle_inputs();
        ld_valid = 1; D = 4'd3; en = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            ld_valid = 0;
            n_tests++;
            if (q !== exp_q[i] || tc !== exp_t[i] || obs !== exp_v) begin
                n_fail++;
                $display("FAIL oneshot[%0d]: got q=%0d tc=%b obs=%b expected q=%0d tc=%b obs=%b",
                         i, q, tc, obs, exp_q[i], exp_t[i], exp_v);
            end
        end
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
        end
        step();
        n_tests++;
        if (tc !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_tc_width: got tc=%b done=%b expected tc=0 done=1", tc, done);
        end
    endtask

    task automatic test_autoreload();
        int n_tc = 0;
        idle_inputs();
        ld_valid = 1; D = 4'd2; auto_rl = 1; en = 1;
        step();
        ld_valid = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (tc) n_tc++;
            n_tests++;
            if (obs !== exp_v || q !== ((i % 2 == 0) ? 4'd1 : 4'd2)) begin
                n_fail++;
                $display("FAIL autoreload[%0d]: got %b expected %b", i, obs, exp_v);
            end
        end
        n_tests++;
        if (n_tc != 3) begin
            n_fail++;
            $display("FAIL autoreload_tc_count: got %0d expected 3", n_tc);
        end
`ifdef CNT_DN_WRAPCNT_EN
        n_tests++;
        if (wraps !== 8'd3) begin
            n_fail++;
            $display("FAIL autoreload_wraps: got %0d expected 3", wraps);
        end
`endif
        auto_rl = 0;
        step();
        n_tests++;
        if (obs !== 8'b0111_0000) begin
            n_fail++;
            $display("FAIL autoreload_stop: got %b expected %b", obs, 8'b0111_0000);
        end
    endtask

    task automatic test_en_toggle();
        idle_inputs();
        ld_valid = 1; D = 4'd5;
        step();
        ld_valid = 0;
        for (int i = 0; i < 4; i++) begin
            en = (i % 2 == 0);
            ld_valid = (i == 1); D = 4'd9;
            step();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL en_toggle[%0d]: got %b expected %b", i, obs, exp_v);
            end
        end
        n_tests++;
        if (q !== 4'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL en_toggle_final: got q=%0d busy=%b expected q=3 busy=1", q, busy);
        end
        clr = 1; en = 0; ld_valid = 0;
        step();
        clr = 0;
    endtask

    task automatic test_zero_load();
        idle_inputs();
        ld_valid = 1; D = 4'd0;
        step();
        n_tests++;
        if (obs !== 8'b0111_0000 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL zero_load: got %b expected %b", obs, 8'b0111_0000);
        end
        D = 4'd15;
        step();
        ld_valid = 0;
        n_tests++;
        if (obs !== 8'b1000_1111) begin
            n_fail++;
            $display("FAIL load_15: got %b expected %b", obs, 8'b1000_1111);
        end
        clr = 1;
        step();
        clr = 0;
    endtask

    task automatic test_clr();
        idle_inputs();
        ld_valid = 1; D = 4'd6;
        step();
        ld_valid = 0; en = 1;
        step(); step();
        n_tests++;
        if (q !== 4'd4) begin
            n_fail++;
            $display("FAIL clr_pre: got q=%0d expected 4", q);
        end
        clr = 1; ld_valid = 1; D = 4'd9;
        step();
        n_tests++;
        if (obs !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL clr_abort: got %b expected %b", obs, 8'b0010_0000);
        end
        clr = 0; D = 4'd7;
        step();
        ld_valid = 0;
        n_tests++;
        if (obs !== 8'b1000_0111) begin
            n_fail++;
            $display("FAIL clr_reload: got %b expected %b", obs, 8'b1000_0111);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 59) == 0);
            clr      = ($urandom_range(0, 29) == 0);
            en       = ($urandom_range(0, 3) != 0);
            auto_rl  = ($urandom_range(0, 1) == 1);
            ld_valid = ($urandom_range(0, 2) == 0);
            D        = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
            step();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b expected %b", i, obs, exp_v);
            end
`ifdef CNT_DN_WRAPCNT_EN
            n_tests++;
            if (wraps !== 8'(m_wraps)) begin
                n_fail++;
                $display("FAIL random_wraps[%0d]: got %0d expected %0d", i, wraps, m_wraps);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_oneshot();
        test_autoreload();
        test_en_toggle();
        test_zero_load();
        test_clr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
